stream_arb_mux: RTL
===================

# stream_arb_mux

Parametrised N-channel arbitrated multiplexer with valid/ready handshakes and a registered output stage. It generalises the plain 2:1 select mux to NUM_CH input streams. Selection is made by an internal arbiter, round-robin or fixed-priority, instead of an external select line. It sits between multiple producer streams and a single consumer wherever a shared datapath must be time-shared without losing or duplicating words.

## Interface
- DATA_WIDTH, 4, width of each data word
- NUM_CH, 4, number of input channels; legal range 2..16, need not be a power of two
- ARB_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)
- clk_in  input  1  single clock; all state updates on the rising edge
- rst_in  input  1  synchronous, active-high reset
- valid_in  input  NUM_CH  per-channel valid; bit i belongs to channel i
- data_in  input  NUM_CH*DATA_WIDTH  flattened channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- ready_out  output  NUM_CH  per-channel ready; combinational
- valid_out  output  1  output register holds a word
- data_out  output  DATA_WIDTH  registered output word
- grant_out  output  CH_W  index of the channel that sourced data_out; registered; CH_W = max(1, clog2(NUM_CH))
- ready_in  input  1  downstream consumer ready

## Operation
- Output register has two states:
  - EMPTY (valid_out=0)
  - FULL (valid_out=1)
- accept = !valid_out || ready_in. This is the condition under which the register can load this cycle.
- Winner selection is combinational from valid_in:
  - Round-robin: the first set valid_in bit at or after rr_ptr, searching upward and wrapping from NUM_CH-1 to 0.
  - Fixed priority: the lowest-index set valid_in bit.
  - No valid bit set means no winner.
- ready_out[i] = accept && winner exists && winner == i. At most one ready_out bit is high in any cycle.
- Transfer on channel i occurs when valid_in[i] && ready_out[i]. On that edge:
  - data_out <= channel i data
  - grant_out <= i
  - valid_out <= 1
  - In round-robin mode, rr_ptr <= (i+1) mod NUM_CH, wrapping explicitly for non-power-of-two NUM_CH.
- EMPTY→FULL: a transfer occurs.
- FULL→EMPTY: ready_in=1 and no transfer occurs that cycle.
- FULL→FULL:
  - With ready_in=1 and a transfer, the output is replaced (pass-through at full throughput).
  - With ready_in=0, the output is held stable.
- While valid_out=1 && ready_in=0, data_out and grant_out must not change.
- rr_ptr does not advance when there is no transfer. Fixed-priority mode never updates rr_ptr.
- Producers must hold valid_in and data unchanged until their transfer occurs. The block does not check this.

## Timing
- Reset values (rst_in high at an edge):
  - valid_out=0
  - data_out=0
  - grant_out=0
  - rr_ptr=0
  - While rst_in is high, ready_out is forced to all zeros.
- Reset mid-operation discards any held output word. The word is lost and no transfer is reported for it.
- Latency is 1 cycle: input transfer at edge N puts the word on data_out after edge N.
- Throughput is one word per cycle when ready_in is held high.
- Path ready_in→ready_out is combinational, through accept. Path valid_in→ready_out is combinational, through the arbiter. No combinational path exists from any input to valid_out, data_out or grant_out.
- Simultaneous requests on all channels in round-robin mode: grants rotate ptr, ptr+1, … Each channel is served exactly once per NUM_CH transfers.
- A channel deasserting valid_in before being granted is legal. The arbiter re-evaluates every cycle.

## Structure
- Shared package mux_pkg holds:
  - ARB_RR=0 and ARB_FIXED=1 constants
  - a clog2 function used for CH_W
- Sub-module rr_arbiter(NUM_CH, ARB_MODE) covers the arbiter alone:
  - inputs: clk_in, rst_in, req_in, advance_in
  - outputs: gnt_valid_out, gnt_idx_out
  - holds rr_ptr and its wrap logic
- stream_arb_mux holds:
  - the output register
  - the accept/ready logic
  - the data select, an indexed part-select driven by gnt_idx_out

## Test plan
- Reset: assert rst_in for 2 cycles with all valid_in=1. Required: ready_out=0, valid_out=0, data_out=0 and grant_out=0 throughout. First grant after release goes to channel 0.
- Round-robin fairness: NUM_CH=4, ARB_MODE=0, all valid_in=1, data_in channel i = i+8, ready_in=1. Required: data_out sequence 8,9,10,11,8,… and grant_out 0,1,2,3,0,…, one word per cycle.
- Fixed priority: ARB_MODE=1, channels 1 and 3 valid, ready_in=1. Required: channel 1 is granted every cycle and ready_out[3] stays 0 until channel 1 drops valid.
- Backpressure: output FULL holding 0xA from channel 2, ready_in=0 for 3 cycles while channel 0 is valid with 0x5. Required:
  - data_out=0xA and grant_out=2 stable for all 3 cycles
  - ready_out=0 during the stall
  - 0x5 appears the cycle after ready_in rises
- Non-power-of-two wrap: NUM_CH=3, rr_ptr at 2, only channel 0 valid. Required: channel 0 is granted and rr_ptr becomes 1. A following all-valid run grants 1,2,0.
- Reset mid-stall: output FULL with ready_in=0, then pulse rst_in for 1 cycle. Required: valid_out=0 the next cycle and the held word is never delivered.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: arbitration mode constants and the width helper shared by the mux and arbiter.
package mux_pkg;
  localparam int ARB_RR = 0;
  localparam int ARB_FIXED = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin or fixed-priority winner selection with a wrapping rotation pointer.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ARB_MODE = ARB_RR,
  localparam int CH_W = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [NUM_CH-1:0] req_in,
  input  logic              advance_in,
  output logic              gnt_valid_out,
  output logic [CH_W-1:0]   gnt_idx_out
);
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  always_comb begin
    int base;
    int j;
    base = (ARB_MODE == ARB_FIXED) ? 0 : int'(rr_ptr_q);
    j = 0;
    gnt_valid_out = 1'b0;
    gnt_idx_out = '0;
    // Walk offsets downward so the smallest offset from the pointer wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = (base + k >= NUM_CH) ? base + k - NUM_CH : base + k;
      if (req_in[j]) begin
        gnt_valid_out = 1'b1;
        gnt_idx_out = CH_W'(j);
      end
    end
  end
  always_comb
    rr_ptr_d = (advance_in && ARB_MODE == ARB_RR)
             ? ((gnt_idx_out == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx_out + CH_W'(1))
             : rr_ptr_q;
  always_ff @(posedge clk_in)
    rr_ptr_q <= rst_in ? '0 : rr_ptr_d;
endmodule

// File: rtl/stream_arb_mux.sv
// stream_arb_mux: arbitrated NUM_CH:1 stream mux with a registered valid/ready output stage.
module stream_arb_mux
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_CH = 4,
  parameter int ARB_MODE = ARB_RR,
  localparam int CH_W = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [NUM_CH-1:0]            valid_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]            ready_out,
  output logic                         valid_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [CH_W-1:0]              grant_out,
  input  logic                         ready_in
);
  logic                  gnt_valid, accept, xfer;
  logic [CH_W-1:0]       gnt_idx;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  rr_arbiter #(.NUM_CH(NUM_CH), .ARB_MODE(ARB_MODE)) u_arb (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .req_in(valid_in),
    .advance_in(xfer),
    .gnt_valid_out(gnt_valid),
    .gnt_idx_out(gnt_idx)
  );
  always_comb begin
    accept = !valid_q || ready_in;
    xfer = accept && gnt_valid && !rst_in;
    ready_out = xfer ? NUM_CH'(1) << gnt_idx : '0;
    valid_d = xfer || (valid_q && !ready_in);
    data_d = xfer ? data_in[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] : data_q;
    grant_d = xfer ? gnt_idx : grant_q;
  end
  always_ff @(posedge clk_in) begin
    valid_q <= rst_in ? 1'b0 : valid_d;
    data_q <= rst_in ? '0 : data_d;
    grant_q <= rst_in ? '0 : grant_d;
  end
  assign valid_out = valid_q;
  assign data_out = data_q;
  assign grant_out = grant_q;
endmodule
